// File: rtl/dm_arbiter.sv
// dm_arbiter: access controller for an external 16-bit data-memory queue.
// Two write requesters and one read requester share the queue. Only one
// memory operation is in flight at a time. The block tracks occupancy,
// full/empty, and a sticky overflow flag ("overset").
// Every output comes straight from a flop.
// Optional feature macro: DM_ARB_FLUSH_EN. It adds a flush input, a mem_clr
// output and a one-cycle FLUSH state.
module dm_arbiter #(
   parameter int DW    = 16,
   parameter int DEPTH = 10,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wreq0,
   input  logic [DW-1:0] wdata0,
   output logic          wgnt0,
   input  logic          wreq1,
   input  logic [DW-1:0] wdata1,
   output logic          wgnt1,
   input  logic          rreq,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   input  logic          clr_ovf,
`ifdef DM_ARB_FLUSH_EN
   input  logic          flush,
   output logic          mem_clr,
`endif
   output logic          mem_wr,
   output logic [DW-1:0] mem_din,
   output logic          mem_rd,
   input  logic [DW-1:0] mem_dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          overset
);

`ifdef DM_ARB_FLUSH_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD      = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_FLUSH   = 3'd4
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR      = 2'd1,
      ST_RD      = 2'd2,
      ST_RD_WAIT = 2'd3
   } state_e;
`endif

   state_e        state_q, state_d;
   logic          rr_q, rr_d;            // 1: requester 1 has priority on a tie
   logic          last_wr_q, last_wr_d;  // 1: the last operation started was a write
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ovf_q, ovf_d;
   logic          wgnt0_q, wgnt0_d;
   logic          wgnt1_q, wgnt1_d;
   logic          mem_wr_q, mem_wr_d;
   logic [DW-1:0] mem_din_q, mem_din_d;
   logic          mem_rd_q, mem_rd_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;
`ifdef DM_ARB_FLUSH_EN
   logic          flush_pend_q, flush_pend_d;
   logic          mem_clr_q, mem_clr_d;
`endif

   // Arbitration decode signals.
   logic w_el0, w_el1, w_any, w_pick1;
   logic rd_avail, r_el;
   logic pick_rd, pick_wr;
   logic ovf_hit;

   // Decide who is eligible and who wins at the current arbitration point.
   always_comb begin
      // A requester granted in this cycle may still show wreq at the edge.
      // Skipping it prevents a second grant for the same request.
      w_el0   = wreq0 && !full_q && !wgnt0_q;
      w_el1   = wreq1 && !full_q && !wgnt1_q;
      w_any   = w_el0 || w_el1;
      w_pick1 = w_el1 && (!w_el0 || rr_q);
      // A read finishing at this edge has already consumed its entry.
      // Another read therefore needs a second unread entry.
      if (state_q == ST_RD_WAIT) begin
         rd_avail = (count_q > CW'(1));
      end else begin
         rd_avail = !empty_q;
      end
      r_el    = rreq && rd_avail && !rvalid_q;
      pick_rd = r_el && (!w_any || last_wr_q);
      pick_wr = w_any && !pick_rd;
      ovf_hit = full_q && ((wreq0 && !wgnt0_q) || (wreq1 && !wgnt1_q));
   end

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      // NOTE: every variable gets a default before the case logic, so no path
      // leaves a value unassigned and no latch is inferred.
      state_d   = state_q;
      rr_d      = rr_q;
      last_wr_d = last_wr_q;
      ovf_d     = ovf_q;
      count_d   = count_q;
      wgnt0_d   = 1'b0;
      wgnt1_d   = 1'b0;
      mem_wr_d  = 1'b0;
      mem_rd_d  = 1'b0;
      rvalid_d  = 1'b0;
      mem_din_d = mem_din_q;
      rdata_d   = rdata_q;
`ifdef DM_ARB_FLUSH_EN
      flush_pend_d = flush_pend_q;
      mem_clr_d    = 1'b0;
`endif

      // The clear is applied first, so a set in the same cycle wins.
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end

      if (state_q == ST_RD) begin
         // No arbitration while a read strobe is out.
         state_d = ST_RD_WAIT;
`ifdef DM_ARB_FLUSH_EN
         // A flush seen here is held until the read completes.
         if (flush) begin
            flush_pend_d = 1'b1;
         end
`endif
      end else begin
         // Read data is valid this cycle; return it and retire the entry.
         if (state_q == ST_RD_WAIT) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_dout;
            if (count_q != '0) begin
               count_d = count_q - CW'(1);
            end
         end

         if (ovf_hit) begin
            ovf_d = 1'b1;
         end

`ifdef DM_ARB_FLUSH_EN
         if (flush || flush_pend_q) begin
            state_d      = ST_FLUSH;
            mem_clr_d    = 1'b1;
            count_d      = '0;
            ovf_d        = 1'b0;
            rr_d         = 1'b0;
            last_wr_d    = 1'b1;
            flush_pend_d = 1'b0;
         end else
`endif
         if (pick_wr) begin
            state_d   = ST_WR;
            mem_wr_d  = 1'b1;
            wgnt0_d   = !w_pick1;
            wgnt1_d   = w_pick1;
            mem_din_d = w_pick1 ? wdata1 : wdata0;
            rr_d      = !w_pick1;
            last_wr_d = 1'b1;
            count_d   = count_d + CW'(1);
         end else if (pick_rd) begin
            state_d   = ST_RD;
            mem_rd_d  = 1'b1;
            last_wr_d = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // State and output registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_q      <= 1'b0;
         last_wr_q <= 1'b1;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
         wgnt0_q   <= 1'b0;
         wgnt1_q   <= 1'b0;
         mem_wr_q  <= 1'b0;
         mem_din_q <= '0;
         mem_rd_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
`ifdef DM_ARB_FLUSH_EN
         flush_pend_q <= 1'b0;
         mem_clr_q    <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments here. Every register then updates
         // from the values sampled at the same edge, regardless of order.
         state_q   <= state_d;
         rr_q      <= rr_d;
         last_wr_q <= last_wr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         ovf_q     <= ovf_d;
         wgnt0_q   <= wgnt0_d;
         wgnt1_q   <= wgnt1_d;
         mem_wr_q  <= mem_wr_d;
         mem_din_q <= mem_din_d;
         mem_rd_q  <= mem_rd_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
`ifdef DM_ARB_FLUSH_EN
         flush_pend_q <= flush_pend_d;
         mem_clr_q    <= mem_clr_d;
`endif
      end
   end

   assign wgnt0   = wgnt0_q;
   assign wgnt1   = wgnt1_q;
   assign mem_wr  = mem_wr_q;
   assign mem_din = mem_din_q;
   assign mem_rd  = mem_rd_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;
   assign overset = ovf_q;
`ifdef DM_ARB_FLUSH_EN
   assign mem_clr = mem_clr_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter.
// Directed scenarios come first, followed by a randomized phase.
// A monitor compares every grant and every read return against queues built
// from the issued stimulus. It also compares occupancy against a
// requests-in / reads-out count.
module tb_dm_arbiter;

   localparam int DW    = 16;
   localparam int DEPTH = 10;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wreq0 = 1'b0, wreq1 = 1'b0, rreq = 1'b0, clr_ovf = 1'b0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          wgnt0, wgnt1, rvalid, mem_wr, mem_rd, full, empty, overset;
   logic [DW-1:0] rdata, mem_din, mem_dout;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] req_q0[$];      // data offered by requester 0, in order
   logic [DW-1:0] req_q1[$];      // data offered by requester 1, in order
   logic [DW-1:0] model_fifo[$];  // accepted data, in grant order
   logic [DW-1:0] mem_q[$];       // external memory contents
   int            rd_due[$];      // cycle index when each rvalid is due
   int            model_count = 0;
   int            neg_n = 0;
   bit            got_gnt0 = 0, got_gnt1 = 0;

   dm_arbiter #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wreq0    (wreq0),
      .wdata0   (wdata0),
      .wgnt0    (wgnt0),
      .wreq1    (wreq1),
      .wdata1   (wdata1),
      .wgnt1    (wgnt1),
      .rreq     (rreq),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .clr_ovf  (clr_ovf),
      .mem_wr   (mem_wr),
      .mem_din  (mem_din),
      .mem_rd   (mem_rd),
      .mem_dout (mem_dout),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .overset  (overset)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // External memory: a plain FIFO; read data appears the cycle after mem_rd.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q.delete();
         mem_dout <= '0;
      end else begin
         if (mem_wr) mem_q.push_back(mem_din);
         if (mem_rd) begin
            if (mem_q.size() > 0) mem_dout <= mem_q.pop_front();
            else                  mem_dout <= 16'hDEAD;
         end
      end
   end

   // Monitor: checks grants, read returns, read latency and occupancy at mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         model_fifo.delete();
         rd_due.delete();
         model_count = 0;
      end else begin
         neg_n++;
         if (wgnt0) begin
            check("wr0_expected", 32'(req_q0.size() != 0), 1);
            if (req_q0.size() != 0) begin
               logic [DW-1:0] d0;
               d0 = req_q0.pop_front();
               check("wr0_din", 32'(mem_din), 32'(d0));
               model_fifo.push_back(d0);
               model_count++;
            end
            got_gnt0 = 1;
         end
         if (wgnt1) begin
            check("wr1_expected", 32'(req_q1.size() != 0), 1);
            if (req_q1.size() != 0) begin
               logic [DW-1:0] d1;
               d1 = req_q1.pop_front();
               check("wr1_din", 32'(mem_din), 32'(d1));
               model_fifo.push_back(d1);
               model_count++;
            end
            got_gnt1 = 1;
         end
         check("single_grant", 32'(wgnt0 & wgnt1), 0);
         check("mem_wr_vs_grant", 32'(mem_wr), 32'(wgnt0 | wgnt1));
         if (mem_rd) rd_due.push_back(neg_n + 2);
         if (rvalid) begin
            check("rd_expected", 32'(model_fifo.size() != 0), 1);
            if (model_fifo.size() != 0) begin
               logic [DW-1:0] dr;
               dr = model_fifo.pop_front();
               check("rd_data", 32'(rdata), 32'(dr));
               model_count--;
            end
            check("rd_issued", 32'(rd_due.size() != 0), 1);
            if (rd_due.size() != 0) check("rd_latency", 32'(neg_n), 32'(rd_due.pop_front()));
         end
         check("count", 32'(count), 32'(model_count));
         check("full", 32'(full), 32'(model_count == DEPTH));
         check("empty", 32'(empty), 32'(model_count == 0));
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      wreq0 = 1'b0; wreq1 = 1'b0; rreq = 1'b0; clr_ovf = 1'b0;
      req_q0.delete();
      req_q1.delete();
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Requester 0 offers one word and holds it until granted; returns at posedge+1.
   task automatic write0(input logic [DW-1:0] d);
      bit seen;
      seen = 0;
      wdata0 = d;
      wreq0  = 1'b1;
      req_q0.push_back(d);
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (wgnt0) seen = 1;
      end
      check("wr0_granted", 32'(seen), 1);
      @(posedge clk); #1;
      wreq0 = 1'b0;
   endtask

   initial begin
      int  gnt_cnt;
      int  n_rv;
      bit  seen;
      bit  drained;

      // Reset state.
      do_reset();
      @(negedge clk);
      check("rst_flags", 32'({wgnt0, wgnt1, rvalid, mem_wr, mem_rd, full, overset, empty}), 32'h01);
      check("rst_count", 32'(count), 0);

      // Single write: grant one cycle after the sampling edge, exactly one cycle wide.
      @(posedge clk); #1;
      wdata0 = 16'h1234; wreq0 = 1'b1; req_q0.push_back(16'h1234);
      @(negedge clk);
      check("wr_not_early", 32'(wgnt0), 0);
      @(posedge clk); @(negedge clk);
      check("wr_grant", 32'({wgnt0, mem_wr}), 32'b11);
      check("wr_din", 32'(mem_din), 32'h1234);
      @(posedge clk); #1;
      wreq0 = 1'b0;
      @(negedge clk);
      check("wr_one_cycle", 32'({wgnt0, mem_wr}), 0);
      check("wr_count", 32'(count), 1);

      // Two writers raised together: round-robin grants 0 then 1.
      do_reset();
      wdata0 = 16'h1111; wreq0 = 1'b1; req_q0.push_back(16'h1111);
      wdata1 = 16'h2222; wreq1 = 1'b1; req_q1.push_back(16'h2222);
      @(posedge clk); @(negedge clk);
      check("rr_first", 32'({wgnt0, wgnt1}), 32'b10);
      check("rr_first_din", 32'(mem_din), 32'h1111);
      @(posedge clk); #1;
      wreq0 = 1'b0;
      @(negedge clk);
      check("rr_second", 32'({wgnt0, wgnt1}), 32'b01);
      check("rr_second_din", 32'(mem_din), 32'h2222);
      @(posedge clk); #1;
      wreq1 = 1'b0;
      @(negedge clk);
      check("rr_idle", 32'({wgnt0, wgnt1}), 0);
      check("rr_count", 32'(count), 2);

      // Fill to capacity, then a refused 11th write sets the sticky overset flag.
      do_reset();
      for (int i = 1; i <= DEPTH; i++) write0(16'(i));
      @(negedge clk);
      check("fill_full", 32'(full), 1);
      check("fill_count", 32'(count), DEPTH);
      check("ovf_before", 32'(overset), 0);
      @(posedge clk); #1;
      wdata0 = 16'h00BB; wreq0 = 1'b1;
      gnt_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (wgnt0) gnt_cnt++;
      end
      check("full_no_grant", 32'(gnt_cnt), 0);
      check("ovf_set", 32'(overset), 1);
      @(posedge clk); #1;
      wreq0 = 1'b0;
      repeat (3) @(negedge clk);
      check("ovf_sticky", 32'(overset), 1);
      @(posedge clk); #1;
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      @(negedge clk);
      check("ovf_cleared", 32'(overset), 0);

      // Drain with rreq held: data comes back 1..DEPTH, then nothing more.
      @(posedge clk); #1;
      rreq = 1'b1;
      n_rv = 0;
      repeat (50) begin
         @(negedge clk);
         if (rvalid) begin
            n_rv++;
            check("drain_order", 32'(rdata), 32'(n_rv));
         end
      end
      @(posedge clk); #1;
      rreq = 1'b0;
      check("drain_reads", 32'(n_rv), DEPTH);
      check("drain_empty", 32'({empty, full}), 32'b10);
      check("drain_count", 32'(count), 0);

      // Contention: read wins after a write; the next contended slot goes to the write.
      do_reset();
      write0(16'h00A1);
      write0(16'h00A2);
      rreq = 1'b1;
      wdata1 = 16'h00B1; wreq1 = 1'b1; req_q1.push_back(16'h00B1);
      @(posedge clk); @(negedge clk);
      check("cont_read_first", 32'({mem_rd, wgnt1}), 32'b10);
      repeat (2) begin @(posedge clk); @(negedge clk); end
      check("cont_write_next", 32'({wgnt1, rvalid}), 32'b11);
      check("cont_rdata", 32'(rdata), 32'h00A1);
      @(posedge clk); #1;
      rreq = 1'b0; wreq1 = 1'b0;
      @(negedge clk);
      check("cont_no_reread", 32'({mem_rd, rvalid, wgnt1}), 0);
      check("cont_count", 32'(count), 2);

      // Reset during RD_WAIT: outputs clear at once, no rvalid afterwards.
      do_reset();
      write0(16'h5555);
      rreq = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_rd) seen = 1;
      end
      check("rstrd_mem_rd", 32'(seen), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("rstrd_flags", 32'({wgnt0, wgnt1, rvalid, mem_wr, mem_rd, full, overset, empty}), 32'h01);
      check("rstrd_count", 32'(count), 0);
      rreq = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rstrd_no_rvalid", 32'(rvalid), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rstrd_after", 32'({rvalid, empty}), 32'b01);
      end

      // Randomized traffic; the monitor carries all checks.
      got_gnt0 = 0; got_gnt1 = 0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if (wreq0 && got_gnt0) begin
            wreq0 = 1'b0; got_gnt0 = 0;
         end else if (!wreq0 && $urandom_range(2) == 0) begin
            wdata0 = 16'($urandom); wreq0 = 1'b1; req_q0.push_back(wdata0);
         end
         if (wreq1 && got_gnt1) begin
            wreq1 = 1'b0; got_gnt1 = 0;
         end else if (!wreq1 && $urandom_range(2) == 0) begin
            wdata1 = 16'($urandom); wreq1 = 1'b1; req_q1.push_back(wdata1);
         end
         rreq    = ($urandom_range(1) == 1);
         clr_ovf = ($urandom_range(7) == 0);
      end

      // Drain: finish pending writes, read everything back.
      clr_ovf = 1'b0;
      drained = 0;
      for (int c = 0; c < 600 && !drained; c++) begin
         @(posedge clk); #1;
         if (wreq0 && got_gnt0) begin wreq0 = 1'b0; got_gnt0 = 0; end
         if (wreq1 && got_gnt1) begin wreq1 = 1'b0; got_gnt1 = 0; end
         rreq = 1'b1;
         if (!wreq0 && !wreq1 && model_count == 0 && rd_due.size() == 0) drained = 1;
      end
      rreq = 1'b0;
      check("rand_drained", 32'(drained), 1);
      repeat (3) @(negedge clk);
      check("rand_final_count", 32'(count), 0);
      check("rand_final_empty", 32'(empty), 1);
      check("rand_fifo_left", 32'(model_fifo.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
